// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM slave state type.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} slv_state_t;

endpackage

// File: rtl/ahb3lite_be_gen.sv
// Little-endian byte-lane enables for a 32-bit AHB data bus.
module ahb3lite_be_gen
    import ahb3lite_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr,
    output logic [3:0] be
);

    always_comb begin
        be = 4'b0000;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite slave on a word-organised memory with configurable wait states and
// a two-cycle ERROR response for illegal size, misalignment or out-of-range accesses.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [HADDR_SIZE-3:0] DEPTH_LIM = (HADDR_SIZE-2)'(MEM_DEPTH);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_t state_q, state_d;
    logic [3:0]            wait_cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            be_q;
    logic                  write_q;
    logic                  pend_q;
    logic [HDATA_SIZE-1:0] hrdata_q;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    logic       ready_out;
    logic       accept;
    logic       err_in;
    logic       final_cyc;
    logic [3:0] be_in;
    logic       unused_ok;

    ahb3lite_be_gen u_be_gen (
        .hsize (HSIZE),
        .addr  (HADDR[1:0]),
        .be    (be_in)
    );

    assign ready_out = (state_q == IDLE) || (state_q == ERR2);
    assign accept    = HSEL & HREADY & HTRANS[1] & ready_out;
    assign err_in    = (HSIZE > HSIZE_WORD)
                     | ((HSIZE == HSIZE_HALF) & HADDR[0])
                     | ((HSIZE == HSIZE_WORD) & (|HADDR[1:0]))
                     | (HADDR[HADDR_SIZE-1:2] >= DEPTH_LIM);
    // pend_q marks an OKAY transfer whose data phase completes when the FSM sits in IDLE
    assign final_cyc = pend_q & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ERR2: begin
                if (accept) begin
                    if (err_in)               state_d = ERR1;
                    else if (WAIT_STATES > 0) state_d = WAIT;
                    else                      state_d = IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT:    state_d = (wait_cnt_q == WS_LAST) ? IDLE : WAIT;
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            be_q       <= 4'b0000;
            write_q    <= 1'b0;
            pend_q     <= 1'b0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + 4'd1 : 4'd0;
            if (accept) begin
                idx_q   <= HADDR[2 +: IDX_W];
                be_q    <= be_in;
                write_q <= HWRITE;
                pend_q  <= ~err_in;
            end else if (final_cyc) begin
                pend_q  <= 1'b0;
            end
            if (accept & err_in)
                hrdata_q <= '0;
            else if (final_cyc & ~write_q)
                hrdata_q <= mem[idx_q];
        end
    end

    // Storage is deliberately not reset; a reset drops pend_q so no write can land
    always_ff @(posedge HCLK) begin
        if (final_cyc & write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HREADYOUT = ready_out;
    assign HRESP     = ((state_q == ERR1) || (state_q == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (final_cyc & ~write_q) ? mem[idx_q] : hrdata_q;
    assign dbg_state = state_q;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: three instances (0, 3 and 2 wait states) share the bus
// inputs; HSEL picks the one under test and a reference memory feeds the read queue.
module tb_ahb3lite_sram_slave;
    import ahb3lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [2:0]  hsel_v;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hrdata_v [3];
    logic [2:0]  hready_v;
    logic [2:0]  hresp_v;
    logic [1:0]  dbg_v [3];

    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [3][64];
    int          n_checks = 0;
    int          n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    for (genvar k = 0; k < 3; k++) begin : g_dut
        ahb3lite_sram_slave #(
            .HADDR_SIZE  (32),
            .HDATA_SIZE  (32),
            .MEM_DEPTH   (256),
            .WAIT_STATES ((k == 0) ? 0 : ((k == 1) ? 3 : 2))
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETn   (HRESETn),
            .HSEL      (hsel_v[k]),
            .HADDR     (haddr),
            .HWDATA    (hwdata),
            .HRDATA    (hrdata_v[k]),
            .HWRITE    (hwrite),
            .HSIZE     (hsize),
            .HBURST    (hburst),
            .HPROT     (hprot),
            .HTRANS    (htrans),
            .HREADY    (hready_v[k]),
            .HREADYOUT (hready_v[k]),
            .HRESP     (hresp_v[k]),
            .dbg_state (dbg_v[k])
        );
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_write(input int inst, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] d);
        int nb;
        int base;
        int lane;
        nb   = (sz == 3'd0) ? 1 : ((sz == 3'd1) ? 2 : 4);
        base = int'(a[1:0]);
        for (int i = 0; i < nb; i++) begin
            lane = base + i;
            ref_mem[inst][a[7:2]][8*lane +: 8] = d[8*lane +: 8];
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) check_val({tag, " queue empty"}, 32'd0, 32'd1);
        else                   check_val(tag, got, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        hsel_v = 3'b000;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_IDLE;
        hburst = 3'd0;
        hprot  = 4'b0011;
    endtask

    // One non-pipelined transfer; called just after a rising edge with the bus idle.
    task automatic xfer(input int inst, input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic exp_err, input int exp_wait,
                        input string tag);
        int lows;
        int guard;
        hsel_v = 3'b001 << inst;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = HTRANS_NONSEQ;
        if (!w && !exp_err) exp_q.push_back(ref_mem[inst][a[7:2]]);
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = d;
        lows  = 0;
        guard = 0;
        @(negedge HCLK);
        while (!hready_v[inst] && guard < 50) begin
            if (exp_err && lows == 0) check_val({tag, " err1 hresp"}, 32'(hresp_v[inst]), 32'd1);
            lows++;
            guard++;
            @(negedge HCLK);
        end
        check_val({tag, " ready"}, 32'(hready_v[inst]), 32'd1);
        check_val({tag, " wait"}, 32'(lows), 32'(exp_wait));
        check_val({tag, " hresp"}, 32'(hresp_v[inst]), 32'(exp_err));
        if (exp_err)    check_val({tag, " hrdata zero"}, hrdata_v[inst], 32'd0);
        else if (!w)    pop_check({tag, " rdata"}, hrdata_v[inst]);
        if (w && !exp_err) model_write(inst, a, sz, d);
        @(posedge HCLK); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [2:0]  sz;
        int          inst;
        int          ws;

        HRESETn = 1'b0;
        hwdata  = 32'h0;
        idle_bus();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 64; j++) ref_mem[i][j] = 32'h0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        for (int i = 0; i < 3; i++) begin
            check_val("reset hreadyout", 32'(hready_v[i]), 32'd1);
            check_val("reset hresp", 32'(hresp_v[i]), 32'd0);
            check_val("reset hrdata", hrdata_v[i], 32'd0);
            check_val("reset state", 32'(dbg_v[i]), 32'(IDLE));
        end
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // Fill the first 16 words of each instance with known data
        for (int i = 0; i < 3; i++) begin
            ws = (i == 0) ? 0 : ((i == 1) ? 3 : 2);
            for (int j = 0; j < 16; j++)
                xfer(i, 1'b1, 32'(j * 4), HSIZE_WORD, $urandom, 1'b0, ws, "init");
        end

        // Word write and read-back, zero wait
        xfer(0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b0, 0, "w10");
        xfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 0, "r10");

        // Byte merge into a word
        xfer(0, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344, 1'b0, 0, "w20");
        xfer(0, 1'b1, 32'h21, HSIZE_BYTE, 32'h0000AA00, 1'b0, 0, "wb21");
        xfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 0, "r20");
        check_val("byte merge model", ref_mem[0][8], 32'h1122AA44);
        xfer(0, 1'b1, 32'h22, HSIZE_HALF, 32'h77660000, 1'b0, 0, "wh22");
        xfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 1'b0, 0, "r20h");

        // Three wait states
        xfer(1, 1'b1, 32'h04, HSIZE_WORD, 32'hCAFEF00D, 1'b0, 3, "ws3 w04");
        xfer(1, 1'b0, 32'h04, HSIZE_WORD, 32'h0, 1'b0, 3, "ws3 r04");

        // Illegal accesses: two-cycle ERROR, memory untouched
        xfer(0, 1'b1, 32'h402, HSIZE_WORD, 32'h12345678, 1'b1, 1, "err 402");
        xfer(0, 1'b1, 32'h400, HSIZE_WORD, 32'h12345678, 1'b1, 1, "err 400");
        xfer(0, 1'b1, 32'h12, HSIZE_WORD, 32'h12345678, 1'b1, 1, "err mis word");
        xfer(0, 1'b1, 32'h13, HSIZE_HALF, 32'h12345678, 1'b1, 1, "err mis half");
        xfer(0, 1'b1, 32'h14, 3'd3, 32'h12345678, 1'b1, 1, "err size3");
        xfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0, 1'b1, 1, "err rd 400");
        xfer(1, 1'b1, 32'h0C1, HSIZE_HALF, 32'h12345678, 1'b1, 1, "ws3 err");
        xfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, 1'b0, 0, "after err r00");
        xfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0, 0, "after err r10");
        xfer(0, 1'b0, 32'h14, HSIZE_WORD, 32'h0, 1'b0, 0, "after err r14");
        xfer(1, 1'b0, 32'h0C, HSIZE_WORD, 32'h0, 1'b0, 3, "after err r0c");

        // BUSY with HSEL high: no access, stays ready
        hsel_v = 3'b010;
        htrans = HTRANS_BUSY;
        haddr  = 32'h8;
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        check_val("busy ready", 32'(hready_v[1]), 32'd1);
        check_val("busy hresp", 32'(hresp_v[1]), 32'd0);
        @(posedge HCLK); #1;

        // Back-to-back write then read to the same word
        hsel_v = 3'b001;
        haddr  = 32'h8;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        hwdata = 32'h5;
        hwrite = 1'b0;
        model_write(0, 32'h8, HSIZE_WORD, 32'h5);
        exp_q.push_back(ref_mem[0][2]);
        @(negedge HCLK);
        check_val("b2b wr ready", 32'(hready_v[0]), 32'd1);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        check_val("b2b rd ready", 32'(hready_v[0]), 32'd1);
        check_val("b2b rd hresp", 32'(hresp_v[0]), 32'd0);
        pop_check("b2b rdata", hrdata_v[0]);
        check_val("b2b literal", hrdata_v[0], 32'h5);
        @(posedge HCLK); #1;

        // Reset in the middle of a wait-stated write
        xfer(2, 1'b1, 32'h30, HSIZE_WORD, 32'h11111111, 1'b0, 2, "rst pre");
        hsel_v = 3'b100;
        haddr  = 32'h30;
        hwrite = 1'b1;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_NONSEQ;
        @(posedge HCLK); #1;
        idle_bus();
        hwdata = 32'h22222222;
        @(negedge HCLK);
        check_val("rst mid low", 32'(hready_v[2]), 32'd0);
        #1 HRESETn = 1'b0;
        #1;
        check_val("rst hreadyout", 32'(hready_v[2]), 32'd1);
        check_val("rst hresp", 32'(hresp_v[2]), 32'd0);
        check_val("rst state", 32'(dbg_v[2]), 32'(IDLE));
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(2, 1'b0, 32'h30, HSIZE_WORD, 32'h0, 1'b0, 2, "rst readback");

        // Random traffic on the zero- and three-wait instances
        for (int n = 0; n < 40; n++) begin
            inst = $urandom_range(0, 1);
            ws   = (inst == 0) ? 0 : 3;
            sz   = 3'($urandom_range(0, 2));
            a    = 32'($urandom_range(0, 15) * 4);
            if (sz == HSIZE_BYTE)      a[1:0] = 2'($urandom_range(0, 3));
            else if (sz == HSIZE_HALF) a[1]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                xfer(inst, 1'b1, a, sz, $urandom, 1'b0, ws, "rand wr");
            else
                xfer(inst, 1'b0, {a[31:2], 2'b00}, HSIZE_WORD, 32'h0, 1'b0, ws, "rand rd");
        end

        check_val("queue drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
